// File: rtl/palette_pkg.sv
// palette_pkg: scene codes, fade FSM states and the full-brightness level shared by the fade path
package palette_pkg;
  typedef enum logic [1:0] {SCENE_SPRITE, SCENE_MAP, SCENE_GYM, SCENE_START} scene_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FADE_OUT = 2'd1;
  localparam state_t ST_SWAP = 2'd2;
  localparam state_t ST_FADE_IN = 2'd3;
  localparam logic [4:0] LEVEL_MAX = 5'd16;
endpackage

// File: rtl/fade_scaler.sv
// fade_scaler: scales one 8-bit colour channel by a 0..16 brightness level
module fade_scaler (
  input  logic [7:0] ch,
  input  logic [4:0] level,
  output logic [7:0] scaled
);
  assign scaled = 8'(({5'd0, ch} * {8'd0, level}) >> 4);
endmodule

// File: rtl/palette_fade_sequencer.sv
// palette_fade_sequencer: fades the palette out, swaps the bank, and fades back in on scene change
module palette_fade_sequencer
  import palette_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        req_valid,
  input  logic [1:0]  req_scene,
  output logic        req_ready,
  output logic [1:0]  select,
  input  logic [23:0] color_in,
  output logic [23:0] color_out,
  output logic [4:0]  fade_level,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic [1:0] target;
  logic [3:0] cnt;
  logic step;
  logic [23:0] scaled;
  assign req_ready = state == ST_IDLE;
  assign busy = !req_ready;
  assign step = frame_tick && cnt == 4'(FRAMES_PER_STEP - 1);
  for (genvar i = 0; i < 3; i++) begin : g_ch
    fade_scaler u_scaler (
      .ch(color_in[8*i +: 8]),
      .level(fade_level),
      .scaled(scaled[8*i +: 8])
    );
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_FADE_IN;
      select <= SCENE_START;
      target <= SCENE_START;
      fade_level <= 5'd0;
      cnt <= 4'd0;
      done <= 1'b0;
      color_out <= 24'd0;
    end else begin
      color_out <= scaled;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          target <= req_scene;
          if (req_scene == select) done <= 1'b1;
          else state <= ST_FADE_OUT;
        end
        ST_FADE_OUT: if (fade_level == 5'd0) state <= ST_SWAP;
          else if (frame_tick) begin
            cnt <= step ? 4'd0 : cnt + 4'd1;
            fade_level <= step ? fade_level - 5'd1 : fade_level;
          end
        ST_SWAP: begin
          select <= target;
          cnt <= 4'd0;
          state <= ST_FADE_IN;
        end
        default: if (fade_level == LEVEL_MAX) begin
            state <= ST_IDLE;
            done <= 1'b1;
          end else if (frame_tick) begin
            cnt <= step ? 4'd0 : cnt + 4'd1;
            fade_level <= step ? fade_level + 5'd1 : fade_level;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_palette_fade_sequencer.sv
// tb_palette_fade_sequencer: randomized scene changes checked against an arithmetic fade model
module tb_palette_fade_sequencer;
  localparam int F = 2;
  logic Clk = 0;
  logic Reset = 1;
  logic frame_tick = 0;
  logic req_valid = 0;
  logic [1:0] req_scene = 0;
  logic req_ready;
  logic [1:0] select;
  logic [23:0] color_in = 0;
  logic [23:0] color_out;
  logic [4:0] fade_level;
  logic busy;
  logic done;
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_color;
  always #5 Clk = ~Clk;
  palette_fade_sequencer #(.FRAMES_PER_STEP(F)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .req_valid(req_valid),
    .req_scene(req_scene), .req_ready(req_ready), .select(select), .color_in(color_in),
    .color_out(color_out), .fade_level(fade_level), .busy(busy), .done(done)
  );
  function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
    scale = {8'(int'(c[23:16]) * lvl / 16), 8'(int'(c[15:8]) * lvl / 16), 8'(int'(c[7:0]) * lvl / 16)};
  endfunction
  task automatic step(input logic t, input logic [23:0] c);
    frame_tick = t;
    color_in = c;
    exp_color = scale(c, int'(fade_level));
    @(posedge Clk);
    #1;
    frame_tick = 0;
  endtask
  task automatic do_fade(input bit down, input int spacing, input int stop, input logic [1:0] sel);
    int n = 0;
    int cyc = 0;
    int gap;
    int lvl;
    logic t;
    lvl = down ? 16 : 0;
    gap = spacing > 0 ? spacing : int'($urandom_range(1, 12));
    while (lvl != stop && cyc < 3000) begin
      gap--;
      t = gap == 0;
      step(t, fade_level == 5'd8 ? 24'hf8d124 : 24'($urandom));
      if (t) begin
        n++;
        gap = spacing > 0 ? spacing : int'($urandom_range(1, 12));
      end
      cyc++;
      lvl = down ? 16 - n / F : n / F;
      checks++;
      if (fade_level !== 5'(lvl)) begin errors++; $display("FAIL fade_level: got %0d expected %0d (ticks %0d)", fade_level, lvl, n); end
      checks++;
      if (color_out !== exp_color) begin errors++; $display("FAIL fade_color: got %h expected %h", color_out, exp_color); end
      checks++;
      if ({busy, req_ready, done} !== 3'b100) begin errors++; $display("FAIL fade_flags busy/ready/done: got %b expected 100", {busy, req_ready, done}); end
      checks++;
      if (select !== sel) begin errors++; $display("FAIL fade_select: got %0d expected %0d", select, sel); end
    end
    checks++;
    if (cyc >= 3000) begin errors++; $display("FAIL fade_timeout: level %0d never reached %0d", fade_level, stop); end
  endtask
  task automatic accept(input logic [1:0] from, input logic [1:0] to);
    req_valid = 1;
    req_scene = to;
    step(1, 24'($urandom));
    req_valid = 0;
    checks++;
    if ({busy, req_ready, done} !== 3'b100) begin errors++; $display("FAIL accept_flags: got %b expected 100", {busy, req_ready, done}); end
    checks++;
    if (fade_level !== 5'd16 || select !== from) begin errors++; $display("FAIL accept_state: level %0d select %0d expected 16 %0d", fade_level, select, from); end
  endtask
  task automatic finish_transition(input logic [1:0] from, input logic [1:0] to);
    do_fade(1, 0, 0, from);
    step(1, 24'($urandom));
    checks++;
    if (select !== from || fade_level !== 5'd0 || busy !== 1'b1) begin errors++; $display("FAIL swap_cycle: select %0d level %0d busy %b expected %0d 0 1", select, fade_level, busy, from); end
    step(1, 24'($urandom));
    checks++;
    if (select !== to || fade_level !== 5'd0 || busy !== 1'b1) begin errors++; $display("FAIL after_swap: select %0d level %0d busy %b expected %0d 0 1", select, fade_level, busy, to); end
    do_fade(0, 0, 16, to);
    step(1, 24'hf8d124);
    checks++;
    if ({busy, req_ready, done} !== 3'b011) begin errors++; $display("FAIL done_flags: got %b expected 011", {busy, req_ready, done}); end
    checks++;
    if (select !== to || fade_level !== 5'd16) begin errors++; $display("FAIL done_state: select %0d level %0d expected %0d 16", select, fade_level, to); end
    checks++;
    if (color_out !== 24'hf8d124) begin errors++; $display("FAIL full_color: got %h expected f8d124", color_out); end
  endtask
  task automatic test_reset;
    Reset = 1;
    repeat (3) step(1, 24'($urandom));
    checks++;
    if (select !== 2'd3 || fade_level !== 5'd0) begin errors++; $display("FAIL reset_state: select %0d level %0d expected 3 0", select, fade_level); end
    checks++;
    if ({busy, req_ready, done} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b expected 100", {busy, req_ready, done}); end
    checks++;
    if (color_out !== 24'h0) begin errors++; $display("FAIL reset_color: got %h expected 000000", color_out); end
    Reset = 0;
  endtask
  task automatic test_power_up;
    step(0, 24'hf8d124);
    checks++;
    if (color_out !== 24'h000000) begin errors++; $display("FAIL level0_color: got %h expected 000000", color_out); end
    do_fade(0, 10, 16, 2'd3);
    step(0, 24'hf8d124);
    checks++;
    if ({busy, req_ready, done} !== 3'b011 || select !== 2'd3) begin errors++; $display("FAIL powerup_done: flags %b select %0d expected 011 3", {busy, req_ready, done}, select); end
    checks++;
    if (color_out !== 24'hf8d124) begin errors++; $display("FAIL level16_color: got %h expected f8d124", color_out); end
    step(0, 24'($urandom));
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL powerup_done_pulse: got %b expected 0", done); end
  endtask
  task automatic test_transition;
    accept(2'd3, 2'd1);
    finish_transition(2'd3, 2'd1);
    step(0, 24'($urandom));
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL transition_idle: done %b busy %b expected 0 0", done, busy); end
  endtask
  task automatic test_same_scene;
    req_valid = 1;
    req_scene = 2'd1;
    step(1, 24'($urandom));
    req_valid = 0;
    checks++;
    if ({busy, req_ready, done} !== 3'b011) begin errors++; $display("FAIL same_done: got %b expected 011", {busy, req_ready, done}); end
    checks++;
    if (fade_level !== 5'd16 || select !== 2'd1) begin errors++; $display("FAIL same_state: level %0d select %0d expected 16 1", fade_level, select); end
    step(1, 24'($urandom));
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL same_pulse: done %b busy %b expected 0 0", done, busy); end
  endtask
  task automatic test_back_to_back;
    logic [1:0] mid;
    mid = $urandom_range(0, 1) == 0 ? 2'd0 : 2'd3;
    accept(2'd1, mid);
    req_valid = 1;
    req_scene = 2'd2;
    finish_transition(2'd1, mid);
    step(0, 24'($urandom));
    req_valid = 0;
    checks++;
    if ({busy, req_ready, done} !== 3'b100 || select !== mid) begin errors++; $display("FAIL b2b_accept: flags %b select %0d expected 100 %0d", {busy, req_ready, done}, select, mid); end
    finish_transition(mid, 2'd2);
    step(0, 24'($urandom));
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b expected 0", done); end
  endtask
  task automatic test_reset_mid;
    logic [1:0] tgt;
    tgt = 2'($urandom_range(0, 2));
    if (tgt == 2'd2) tgt = 2'd3;
    accept(2'd2, tgt);
    do_fade(1, 0, 9, 2'd2);
    Reset = 1;
    step(1, 24'($urandom));
    checks++;
    if (select !== 2'd3 || fade_level !== 5'd0) begin errors++; $display("FAIL midreset_state: select %0d level %0d expected 3 0", select, fade_level); end
    checks++;
    if ({busy, req_ready, done} !== 3'b100 || color_out !== 24'h0) begin errors++; $display("FAIL midreset_flags: flags %b color %h expected 100 000000", {busy, req_ready, done}, color_out); end
    Reset = 0;
    do_fade(0, 0, 16, 2'd3);
    step(0, 24'($urandom));
    checks++;
    if ({busy, req_ready, done} !== 3'b011 || select !== 2'd3) begin errors++; $display("FAIL midreset_done: flags %b select %0d expected 011 3", {busy, req_ready, done}, select); end
  endtask
  initial begin
    test_reset;
    test_power_up;
    test_transition;
    test_same_scene;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
